div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Upstream issue/sequencing stage for the 32-bit iterative signed divider.
- Accepts a divide request from the execute stage and latches the operands and destination register.
- Drives the divider's one-cycle start pulse, stalls the pipeline while the divider iterates, then presents the quotient and divide-by-zero flag to writeback with a valid/ack handshake.
- Masks the divider's stale ready level left over from the previous operation.

Parameters:
- WIDTH, 32: operand/result width.
- MIN_LAT, 3: cycles after start before div_ready is trusted.
- MAX_LAT, 64: watchdog limit; cycles in WAIT before forced completion with timeout flag.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a divide.
- req_ready  out  1  block can accept; high only in IDLE.
- req_opA  in  WIDTH  dividend, signed.
- req_opB  in  WIDTH  divisor, signed.
- req_dest  in  5  destination register number.
- div_operandA  out  WIDTH  latched dividend to divider; stable from START through DONE.
- div_operandB  out  WIDTH  latched divisor to divider; stable from START through DONE.
- div_start  out  1  one-cycle start pulse to divider.
- div_result  in  WIDTH  divider quotient.
- div_overflow  in  1  divider divide-by-zero flag.
- div_ready  in  1  divider done level.
- stall  out  1  freeze upstream pipeline.
- wb_valid  out  1  result available.
- wb_ack  in  1  writeback consumed result.
- wb_data  out  WIDTH  quotient; 0 on exception.
- wb_dest  out  5  latched destination.
- wb_exception  out  1  divide-by-zero or timeout.
- wb_timeout  out  1  watchdog fired.

Behaviour:
- Reset: state=IDLE, req_ready=1, div_start=0, stall=0, wb_valid=0, wb_data=0, wb_dest=0, wb_exception=0, wb_timeout=0, operand registers=0, cycle counter=0. Reset mid-operation abandons the op: no writeback occurs, and the divider is left to finish unobserved.
- States:
  - IDLE: on req_valid, latch opA, opB and dest; go to START.
  - START: div_start=1 for exactly this cycle; counter cleared; go to WAIT.
  - WAIT: counter increments each cycle, saturating at MAX_LAT.
    - If counter>=MIN_LAT and div_ready: capture div_result and div_overflow; go to DONE.
    - Else if counter==MAX_LAT-1: set wb_timeout; go to DONE.
  - DONE: wb_valid=1 and outputs held until wb_ack sampled high, then go to IDLE.
- Stall: stall=1 in START, in WAIT, and in DONE while wb_ack is low. stall=0 in IDLE.
- Completion latency: request accepted in cycle N → div_start in N+1 → wb_valid one cycle after the first trusted div_ready.
- wb_exception = div_overflow | timeout.
- wb_data = 0 when wb_exception=1, otherwise the captured quotient.
- Ready masking: div_ready high before MIN_LAT is ignored; this is the stale level from the prior operation.
- Back-to-back issue: wb_ack and req_valid high together in DONE → return to IDLE; the new request is accepted in the following cycle. There is no same-cycle bypass.
- req_valid while not in IDLE is ignored; req_ready=0.
- wb_ack outside DONE has no effect.
- Operand registers are not updated outside IDLE acceptance.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if req_valid and req_opB==0, skip START/WAIT and go directly to DONE with wb_exception=1, wb_data=0, wb_timeout=0.
  - div_start is never pulsed for that request.
  - Latency from accept to wb_valid is 1 cycle.
- Undefined: a zero divisor follows the normal path, and the exception comes from div_overflow.

Test Plan:
- req opA=100, opB=7, dest=5; model divider asserts ready 33 cycles after start → single div_start pulse; wb_valid with wb_data=14, wb_dest=5, wb_exception=0; stall low after ack.
- opA=-100, opB=7 → wb_data=0xFFFFFFF2 (-14); div_ready held high from the prior op during the first 2 WAIT cycles is ignored.
- opB=0 → without macro: div_start pulses, and divider overflow yields wb_exception=1, wb_data=0. With DIV_ZERO_BYPASS_EN: no div_start, and wb_valid comes 1 cycle after accept.
- Divider never asserts ready → wb_timeout=1, wb_exception=1 at counter 63; block returns to IDLE after wb_ack.
- Assert reset for one cycle mid-WAIT → all outputs at reset values next cycle; no wb_valid; the next request completes normally.
- wb_ack withheld 5 cycles, then wb_ack and req_valid together → outputs held stable for 5 cycles; the new request is accepted the cycle after returning to IDLE.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Issue/writeback bundle between the execute stage, the divider issue controller, the iterative
// divider and writeback. The controller takes the slave view; the surrounding logic the master.
interface div_issue_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_opA;
  logic [WIDTH-1:0] req_opB;
  logic [4:0]       req_dest;

  logic [WIDTH-1:0] div_operandA;
  logic [WIDTH-1:0] div_operandB;
  logic             div_start;
  logic [WIDTH-1:0] div_result;
  logic             div_overflow;
  logic             div_ready;

  logic             stall;
  logic             wb_valid;
  logic             wb_ack;
  logic [WIDTH-1:0] wb_data;
  logic [4:0]       wb_dest;
  logic             wb_exception;
  logic             wb_timeout;

  modport slave (
    input  req_valid, req_opA, req_opB, req_dest, div_result, div_overflow, div_ready, wb_ack,
    output req_ready, div_operandA, div_operandB, div_start, stall, wb_valid, wb_data, wb_dest,
           wb_exception, wb_timeout
  );

  modport master (
    output req_valid, req_opA, req_opB, req_dest, div_result, div_overflow, div_ready, wb_ack,
    input  req_ready, div_operandA, div_operandB, div_start, stall, wb_valid, wb_data, wb_dest,
           wb_exception, wb_timeout
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing controller for the iterative signed divider: start pulse, stall, watchdog and
// writeback handshake. Define DIV_ZERO_BYPASS_EN to complete zero-divisor requests without the divider.
module div_issue_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MIN_LAT = 3,
  parameter int unsigned MAX_LAT = 64
) (
  input logic             clock,
  input logic             reset,
  div_issue_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       dest_q, dest_d;
  logic             exc_q, exc_d;
  logic             tmo_q, tmo_d;
  logic             accept, ready_ok, wd_fire, zero_div;

  assign accept   = (state_q == StIdle) && bus.req_valid;
  // Ready seen before MIN_LAT is the level left over from the previous operation.
  assign ready_ok = (cnt_q >= CntW'(MIN_LAT)) && bus.div_ready;
  assign wd_fire  = !ready_ok && (cnt_q == CntW'(MAX_LAT - 1));

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_div = (bus.req_opB == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = zero_div ? StDone : StStart;
      StStart: state_d = StWait;
      StWait:  if (ready_ok || wd_fire) state_d = StDone;
      StDone:  if (bus.wb_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.div_start = (state_q == StStart);
    bus.wb_valid  = (state_q == StDone);
    bus.stall     = (state_q == StStart) || (state_q == StWait) ||
                    ((state_q == StDone) && !bus.wb_ack);
  end

  always_comb begin
    cnt_d  = cnt_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    dest_d = dest_q;
    data_d = data_q;
    exc_d  = exc_q;
    tmo_d  = tmo_q;
    if (accept) begin
      opa_d  = bus.req_opA;
      opb_d  = bus.req_opB;
      dest_d = bus.req_dest;
      if (zero_div) begin
        data_d = '0;
        exc_d  = 1'b1;
        tmo_d  = 1'b0;
      end
    end
    if (state_q == StStart) begin
      cnt_d = '0;
    end
    if (state_q == StWait) begin
      if (cnt_q != CntW'(MAX_LAT)) cnt_d = cnt_q + CntW'(1);
      if (ready_ok) begin
        exc_d  = bus.div_overflow;
        tmo_d  = 1'b0;
        data_d = bus.div_overflow ? '0 : bus.div_result;
      end else if (wd_fire) begin
        exc_d  = 1'b1;
        tmo_d  = 1'b1;
        data_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      dest_q <= '0;
      data_q <= '0;
      exc_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      dest_q <= dest_d;
      data_q <= data_d;
      exc_q  <= exc_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.div_operandA = opa_q;
  assign bus.div_operandB = opb_q;
  assign bus.wb_data      = data_q;
  assign bus.wb_dest      = dest_q;
  assign bus.wb_exception = exc_q;
  assign bus.wb_timeout   = tmo_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: cycle-timeline reference model, behavioural divider and directed tests.
module tb_div_issue_ctrl;
  localparam int unsigned W      = 32;
  localparam int unsigned MinLat = 3;
  localparam int unsigned MaxLat = 64;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif
  localparam int ZeroLat = Bypass ? 1 : 7;

  logic clock = 1'b0;
  logic reset = 1'b1;

  div_issue_ctrl_if #(.WIDTH(W)) bus ();

  div_issue_ctrl #(
    .WIDTH  (W),
    .MIN_LAT(MinLat),
    .MAX_LAT(MaxLat)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  bit started = 1'b0;

  typedef enum int {MIdle, MBusy, MDone} mphase_e;
  mphase_e     ph        = MIdle;
  int          m_acc     = 0;
  int          m_start   = 0;
  logic [31:0] m_opa     = '0;
  logic [31:0] m_opb     = '0;
  logic [31:0] m_data    = '0;
  logic [4:0]  m_dest    = '0;
  bit          m_exc     = 1'b0;
  bit          m_tmo     = 1'b0;
  bit          m_fresh   = 1'b1;

  // Divider behaviour: ready rises rdy_after cycles after start (never if negative) and stays high;
  // it is also forced high up to stale cycles past start to mimic the previous op's level.
  int rdy_after = -1;
  int stale     = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  // Reference model: one step per clock edge, in terms of cycles since acceptance.
  always @(posedge clock) begin : model
    int k;
    started = 1'b1;
    if (reset) begin
      ph = MIdle; m_opa = '0; m_opb = '0; m_dest = '0;
      m_data = '0; m_exc = 1'b0; m_tmo = 1'b0; m_fresh = 1'b1;
    end else begin
      case (ph)
        MIdle: if (bus.req_valid) begin
          m_acc = cyc; m_fresh = 1'b0;
          m_opa = bus.req_opA; m_opb = bus.req_opB; m_dest = bus.req_dest;
          if (Bypass && bus.req_opB == 32'd0) begin
            ph = MDone; m_data = '0; m_exc = 1'b1; m_tmo = 1'b0;
          end else begin
            ph = MBusy; m_start = cyc + 1;
          end
        end
        MBusy: if (cyc > m_start) begin
          k = cyc - m_start - 1;
          if (k >= int'(MinLat) && bus.div_ready) begin
            ph = MDone; m_exc = bus.div_overflow; m_tmo = 1'b0;
            m_data = bus.div_overflow ? 32'd0 : bus.div_result;
          end else if (k == int'(MaxLat) - 1) begin
            ph = MDone; m_exc = 1'b1; m_tmo = 1'b1; m_data = '0;
          end
        end
        MDone: if (bus.wb_ack) ph = MIdle;
        default: ph = MIdle;
      endcase
    end
    cyc++;
  end

  always @(posedge clock) begin
    #1;
    bus.div_ready    = (rdy_after >= 0 && cyc >= m_start + rdy_after) || (cyc <= m_start + stale);
    bus.div_overflow = (m_opb == 32'd0);
    bus.div_result   = (m_opb == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(m_opa) / $signed(m_opb));
  end

  always @(negedge clock) begin
    if (started) begin
      chk("req_ready", 32'(bus.req_ready), 32'(ph == MIdle));
      chk("div_start", 32'(bus.div_start), 32'(ph == MBusy && cyc == m_start));
      chk("stall", 32'(bus.stall), 32'(ph == MBusy || (ph == MDone && !bus.wb_ack)));
      chk("wb_valid", 32'(bus.wb_valid), 32'(ph == MDone));
      chk("div_operandA", bus.div_operandA, m_opa);
      chk("div_operandB", bus.div_operandB, m_opb);
      if (ph == MDone || m_fresh) begin
        chk("wb_data", bus.wb_data, m_data);
        chk("wb_dest", 32'(bus.wb_dest), 32'(m_dest));
        chk("wb_exception", 32'(bus.wb_exception), 32'(m_exc));
        chk("wb_timeout", 32'(bus.wb_timeout), 32'(m_tmo));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    bus.req_valid = 1'b1; bus.req_opA = a; bus.req_opB = b; bus.req_dest = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (ph != MDone && n < bound) begin
      tick();
      n++;
    end
    chk("wb_valid_within_bound", 32'(bus.wb_valid), 32'd1);
  endtask

  task automatic ack();
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_opA = '0; bus.req_opB = '0; bus.req_dest = '0;
    bus.wb_ack = 1'b0; bus.div_ready = 1'b0; bus.div_overflow = 1'b0; bus.div_result = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // 100 / 7, ready 33 cycles after start
    rdy_after = 33; stale = 0;
    issue(32'd100, 32'd7, 5'd5);
    wait_done(60);
    chk("t1_data", bus.wb_data, 32'd14);
    chk("t1_dest", 32'(bus.wb_dest), 32'd5);
    chk("t1_exc", 32'(bus.wb_exception), 32'd0);
    chk("t1_latency", 32'(cyc - m_acc), 32'd35);
    ack();
    chk("t1_stall_after_ack", 32'(bus.stall), 32'd0);

    // -100 / 7 with stale ready over the masked WAIT cycles
    rdy_after = 10; stale = 3;
    issue(32'hFFFF_FF9C, 32'd7, 5'd9);
    wait_done(40);
    chk("t2_data", bus.wb_data, 32'hFFFF_FFF2);
    chk("t2_latency", 32'(cyc - m_acc), 32'd12);
    ack();
    stale = 0;

    // divide by zero
    rdy_after = 5;
    issue(32'd55, 32'd0, 5'd3);
    wait_done(40);
    chk("t3_exc", 32'(bus.wb_exception), 32'd1);
    chk("t3_data", bus.wb_data, 32'd0);
    chk("t3_tmo", 32'(bus.wb_timeout), 32'd0);
    chk("t3_latency", 32'(cyc - m_acc), 32'(ZeroLat));
    ack();

    // divider never ready: watchdog
    rdy_after = -1;
    issue(32'd1000, 32'd3, 5'd7);
    wait_done(80);
    chk("t4_tmo", 32'(bus.wb_timeout), 32'd1);
    chk("t4_exc", 32'(bus.wb_exception), 32'd1);
    chk("t4_data", bus.wb_data, 32'd0);
    chk("t4_latency", 32'(cyc - m_acc), 32'd66);
    ack();
    chk("t4_idle", 32'(bus.req_ready), 32'd1);

    // reset mid-WAIT abandons the op
    rdy_after = 33;
    issue(32'd20, 32'd4, 5'd2);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ready", 32'(bus.req_ready), 32'd1);
    chk("t5_stall", 32'(bus.stall), 32'd0);
    chk("t5_valid", 32'(bus.wb_valid), 32'd0);
    chk("t5_opA", bus.div_operandA, 32'd0);
    chk("t5_dest", 32'(bus.wb_dest), 32'd0);
    repeat (40) tick();
    chk("t5_no_wb", 32'(bus.wb_valid), 32'd0);
    rdy_after = 8;
    issue(32'hFFFF_FFEB, 32'hFFFF_FFFC, 5'd31);
    wait_done(40);
    chk("t5_data", bus.wb_data, 32'd5);
    chk("t5_dest_new", 32'(bus.wb_dest), 32'd31);
    ack();

    // ack withheld 5 cycles, then ack together with a new request
    rdy_after = 4;
    issue(32'd9, 32'd2, 5'd12);
    wait_done(40);
    chk("t6_latency", 32'(cyc - m_acc), 32'd6);
    for (int i = 0; i < 5; i++) begin
      chk("t6_hold_data", bus.wb_data, 32'd4);
      chk("t6_hold_valid", 32'(bus.wb_valid), 32'd1);
      tick();
    end
    bus.req_valid = 1'b1; bus.req_opA = 32'd77; bus.req_opB = 32'd7; bus.req_dest = 5'd1;
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    chk("t6_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("t6_idle_opA", bus.div_operandA, 32'd9);
    tick();
    bus.req_valid = 1'b0;
    chk("t6_start", 32'(bus.div_start), 32'd1);
    chk("t6_new_opA", bus.div_operandA, 32'd77);
    wait_done(40);
    chk("t6_data", bus.wb_data, 32'd11);
    chk("t6_dest", 32'(bus.wb_dest), 32'd1);
    ack();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
